bcd_updown_counter: RTL

Parametrised N-digit BCD up/down counter with direct 7-segment drive. It is the successor to the fixed 2-digit divider/counter/display chain. It counts in native BCD, so no divide or modulo is needed for digit split. Counting is driven by either an internal prescaler tick (auto mode) or an external single-step pulse (manual mode), with load, enable, a programmable modulus, and a wrap or saturate policy. It sits between board I/O (switches, debounced key) and the HEX displays.

---
 rtl/bcd_pkg.sv | 37 +++
 rtl/bcd_to_7seg.sv | 16 +
 rtl/bcd_updown_counter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD up/down counter and its 7-segment decoders.
// Segment codes are active-low with bit order g..a (bit 6 = g).
package bcd_pkg;

   localparam int SEG_W      = 7;
   localparam int MAX_DIGITS = 6;

   localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

   // Element i is the glyph for decimal digit i.
   localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
      7'b0010000,
      7'b0000000,
      7'b1111000,
      7'b0000010,
      7'b0010010,
      7'b0011001,
      7'b0110000,
      7'b0100100,
      7'b1111001,
      7'b1000000
   };

   // Builds a BCD constant from a decimal value; digit 0 lands in bits [3:0].
   function automatic logic [4*MAX_DIGITS-1:0] dec_to_bcd(input int value, input int digits);
      logic [4*MAX_DIGITS-1:0] bcd;
      int                      v;
      bcd = '0;
      v   = value;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (i < digits) bcd[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return bcd;
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Single BCD digit to active-low 7-segment code (g..a).
// Non-decimal nibbles never reach here in normal use; they blank the display.
module bcd_to_7seg
   import bcd_pkg::*;
(
   input  logic [3:0]       digit_i,
   output logic [SEG_W-1:0] seg_o
);

   // NOTE: combinational outputs get a default first so no path can infer a latch.
   always_comb begin
      seg_o = SEG_OFF;
      if (digit_i <= 4'd9) seg_o = SEG_TABLE[digit_i];
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with prescaler or manual-step counting, clamped load,
// wrap/saturate policy and direct active-low 7-segment drive for every digit.
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS    = 2,
   parameter int CLK_DIV   = 25000000,
   parameter int MAX_VALUE = 99,
   parameter bit SATURATE  = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    up,
   input  logic                    mode,
   input  logic                    step,
   input  logic                    load,
   input  logic [4*DIGITS-1:0]     load_value,
   output logic [4*DIGITS-1:0]     count_bcd,
   output logic [SEG_W*DIGITS-1:0] seg,
   output logic                    tick,
   output logic                    wrap
);

   localparam int                      BW       = 4 * DIGITS;
   localparam int                      PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0]           PSC_LAST = PW'(CLK_DIV - 1);
   localparam logic [4*MAX_DIGITS-1:0] MAX_FULL = dec_to_bcd(MAX_VALUE, DIGITS);
   localparam logic [BW-1:0]           MAX_BCD  = MAX_FULL[BW-1:0];

   logic [PW-1:0] psc_q, psc_d;
   logic          step_q;
   logic [BW-1:0] count_q, count_d;
   logic          wrap_q, wrap_d;

   logic          tick_w, step_rise, ev, at_max, at_zero, load_valid;
   logic [BW-1:0] inc_bcd, dec_bcd, load_bcd;

   assign tick_w    = (psc_q == PSC_LAST);
   assign psc_d     = tick_w ? '0 : psc_q + PW'(1);
   assign step_rise = step & ~step_q;
   assign ev        = en & (mode ? step_rise : tick_w);
   assign at_max    = (count_q == MAX_BCD);
   assign at_zero   = (count_q == '0);

   // Valid BCD orders the same as plain binary, so the bound check needs no decode.
   always_comb begin
      load_valid = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_value[4*i +: 4] > 4'd9) load_valid = 1'b0;
      end
      load_bcd = (load_valid && (load_value <= MAX_BCD)) ? load_value : MAX_BCD;
   end

   // Digit-wise ripple: carry/borrow only propagates past digits sitting at 9 / 0.
   always_comb begin
      logic       carry;
      logic       borrow;
      logic [3:0] dig;
      carry   = 1'b1;
      borrow  = 1'b1;
      dig     = '0;
      inc_bcd = count_q;
      dec_bcd = count_q;
      for (int i = 0; i < DIGITS; i++) begin
         dig = count_q[4*i +: 4];
         if (carry) begin
            inc_bcd[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
            carry             = (dig == 4'd9);
         end
         if (borrow) begin
            dec_bcd[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            borrow            = (dig == 4'd0);
         end
      end
   end

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (load) begin
         count_d = load_bcd;
      end else if (ev) begin
         if (up) begin
            if (at_max) begin
               count_d = SATURATE ? count_q : '0;
               wrap_d  = 1'b1;
            end else begin
               count_d = inc_bcd;
            end
         end else begin
            if (at_zero) begin
               count_d = SATURATE ? count_q : MAX_BCD;
               wrap_d  = 1'b1;
            end else begin
               count_d = dec_bcd;
            end
         end
      end
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         psc_q   <= '0;
         step_q  <= 1'b0;
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         psc_q   <= psc_d;
         step_q  <= step;
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count_bcd = count_q;
   assign tick      = tick_w;
   assign wrap      = wrap_q;

   for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      bcd_to_7seg u_dec (
         .digit_i (count_q[4*g +: 4]),
         .seg_o   (seg[SEG_W*g +: SEG_W])
      );
   end

endmodule
